// File: rtl/dp_pkg.sv
// Shared types and pure datapath helpers for seq_datapath.
// Latency: none (types and combinational functions only).
// Backpressure: not applicable.
package dp_pkg;

    // Widest datapath word the helper functions handle.
    localparam int DP_MAX_W = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        WB_C     = 2'b00,
        WB_PC    = 2'b01,
        WB_IMM   = 2'b10,
        WB_MDATA = 2'b11
    } wsel_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

    // Operand is zero-extended into 64 bits; msb_idx marks the real word's
    // sign bit so ASR can replicate it. Caller truncates the return value.
    function automatic logic [DP_MAX_W-1:0] shift_f(input logic [DP_MAX_W-1:0] b,
                                                    input logic [5:0]          msb_idx,
                                                    input shift_e              sh);
        logic [DP_MAX_W-1:0] r;
        logic [DP_MAX_W-1:0] sign_fill;
        sign_fill = {{(DP_MAX_W-1){1'b0}}, b[msb_idx]} << msb_idx;
        case (sh)
            SH_LSL1: r = b << 1;
            SH_LSR1: r = b >> 1;
            SH_ASR1: r = (b >> 1) | sign_fill;
            default: r = b;
        endcase
        return r;
    endfunction

    // Word-width agnostic ALU; caller truncates to its own width, which
    // makes ADD/SUB wrap modulo 2^width.
    function automatic logic [DP_MAX_W-1:0] alu_f(input logic [DP_MAX_W-1:0] a,
                                                  input logic [DP_MAX_W-1:0] b,
                                                  input alu_op_e             op);
        logic [DP_MAX_W-1:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            default: r = ~b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: NREG x DATA_W, one write port, operand and debug read ports.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; a write is taken whenever we is high.
module dp_regfile
    import dp_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREG];

    // Clear every register on reset, otherwise apply the single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata    = regs[raddr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: accepts an op descriptor, reads A, reads B, executes, writes back.
// Latency: done pulses in the 4th cycle after accept; one op per 5 cycles.
// Backpressure: op_ready high only in IDLE; op_valid while busy is ignored.
module seq_datapath
    import dp_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    parameter  int PC_W   = 9,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        alu_op,
    input  logic [1:0]        shift,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic [REG_AW-1:0] rd,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        wsel,
    input  logic              wb_en,
    input  logic              set_flags,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] mdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              z_out,
    output logic              n_out,
    output logic              v_out,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef struct packed {
        alu_op_e           alu_op;
        shift_e            shift;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
        logic [REG_AW-1:0] rd;
        logic              asel;
        logic              bsel;
        logic [DATA_W-1:0] imm;
        wsel_e             wsel;
        logic              wb_en;
        logic              set_flags;
    } desc_t;

    localparam int MSB = DATA_W - 1;

    state_e            state_q, state_d;
    desc_t             desc_in, desc_q;
    logic              accept;
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              z_q, n_q, v_q;
    logic [REG_AW-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] ain, bin, alu_res;
    logic              ovf;

    // Pack the live descriptor inputs; only sampled on accept.
    always_comb begin
        desc_in           = '0;
        desc_in.alu_op    = alu_op_e'(alu_op);
        desc_in.shift     = shift_e'(shift);
        desc_in.rn        = rn;
        desc_in.rm        = rm;
        desc_in.rd        = rd;
        desc_in.asel      = asel;
        desc_in.bsel      = bsel;
        desc_in.imm       = imm;
        desc_in.wsel      = wsel_e'(wsel);
        desc_in.wb_en     = wb_en;
        desc_in.set_flags = set_flags;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state and handshake outputs: fixed walk through the phases.
    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_d = RD_A;
                end
            end
            RD_A:    state_d = RD_B;
            RD_B:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = op_valid && op_ready;

    // Latch the whole descriptor at accept so inputs are free for the rest of the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            desc_q <= '0;
        end else if (accept) begin
            desc_q <= desc_in;
        end
    end

    // One read port serves both operand fetches: rn in RD_A, rm otherwise.
    assign rf_raddr = (state_q == RD_A) ? desc_q.rn : desc_q.rm;

    // Operand pipeline registers A and B.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state_q == RD_A) begin
            a_q <= rf_rdata;
        end else if (state_q == RD_B) begin
            b_q <= rf_rdata;
        end
    end

    // Execute-stage operand selection, ALU and signed-overflow detection.
    always_comb begin
        ain     = desc_q.asel ? '0 : a_q;
        bin     = desc_q.bsel ? desc_q.imm
                              : DATA_W'(shift_f(64'(b_q), 6'(MSB), desc_q.shift));
        alu_res = DATA_W'(alu_f(64'(ain), 64'(bin), desc_q.alu_op));
        ovf     = 1'b0;
        case (desc_q.alu_op)
            ALU_ADD: ovf = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            ALU_SUB: ovf = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            default: ovf = 1'b0;
        endcase
    end

    // Result register C and status flags; flags only move when the op asks.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state_q == EXEC) begin
            c_q <= alu_res;
            if (desc_q.set_flags) begin
                z_q <= (alu_res == '0);
                n_q <= alu_res[MSB];
                v_q <= ovf;
            end
        end
    end

    // Writeback source mux; pc and mdata are taken live during WB.
    always_comb begin
        rf_we    = (state_q == WB) && desc_q.wb_en;
        rf_wdata = c_q;
        case (desc_q.wsel)
            WB_C:     rf_wdata = c_q;
            WB_PC:    rf_wdata = DATA_W'(pc);
            WB_IMM:   rf_wdata = desc_q.imm;
            default:  rf_wdata = mdata;
        endcase
    end

    dp_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (desc_q.rd),
        .wdata    (rf_wdata),
        .raddr    (rf_raddr),
        .rdata    (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign result = c_q;
    assign z_out  = z_q;
    assign n_out  = n_q;
    assign v_out  = v_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath (DATA_W=16, NREG=8, PC_W=9).
// Drives and samples 1 time unit after each rising edge.
// Reference model works on plain integers and a register array.
module tb_seq_datapath;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [2:0]  rn, rm, rd;
    logic        asel, bsel;
    logic [15:0] imm;
    logic [1:0]  wsel;
    logic        wb_en;
    logic        set_flags;
    logic [8:0]  pc;
    logic [15:0] mdata;
    logic        done;
    logic [15:0] result;
    logic        z_out, n_out, v_out;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int   ref_r [8];
    int   ref_c;
    logic ref_z, ref_n, ref_v;

    seq_datapath #(.DATA_W(16), .NREG(8), .PC_W(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .alu_op    (alu_op),
        .shift     (shift),
        .rn        (rn),
        .rm        (rm),
        .rd        (rd),
        .asel      (asel),
        .bsel      (bsel),
        .imm       (imm),
        .wsel      (wsel),
        .wb_en     (wb_en),
        .set_flags (set_flags),
        .pc        (pc),
        .mdata     (mdata),
        .done      (done),
        .result    (result),
        .z_out     (z_out),
        .n_out     (n_out),
        .v_out     (v_out),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_r[i] = 0;
        ref_c = 0;
        ref_z = 1'b0;
        ref_n = 1'b0;
        ref_v = 1'b0;
    endtask

    task automatic scramble();
        alu_op    = 2'($urandom);
        shift     = 2'($urandom);
        rn        = 3'($urandom);
        rm        = 3'($urandom);
        rd        = 3'($urandom);
        asel      = 1'($urandom);
        bsel      = 1'($urandom);
        imm       = 16'($urandom);
        wsel      = 2'($urandom);
        wb_en     = 1'($urandom);
        set_flags = 1'($urandom);
        pc        = 9'($urandom);
        mdata     = 16'($urandom);
    endtask

    // Issue one op from IDLE, follow it through every phase and check it.
    task automatic do_op(input int op, input int sh, input int rn_i, input int rm_i,
                         input int rd_i, input int as_i, input int bs_i, input int imm_i,
                         input int ws_i, input int we_i, input int sf_i, input int pc_i,
                         input int md_i, input string tag);
        int a, b, ain, bin, res, sa, sb, sr, wv, exp_reg;
        bit busy_ok;
        a = ref_r[rn_i];
        b = ref_r[rm_i];
        ain = (as_i != 0) ? 0 : a;
        if (bs_i != 0) bin = imm_i;
        else begin
            case (sh)
                1:       bin = (b * 2) % 65536;
                2:       bin = b / 2;
                3:       bin = b / 2 + ((b >= 32768) ? 32768 : 0);
                default: bin = b;
            endcase
        end
        sa = (ain >= 32768) ? ain - 65536 : ain;
        sb = (bin >= 32768) ? bin - 65536 : bin;
        case (op)
            0:       begin res = (ain + bin) % 65536;         sr = sa + sb; end
            1:       begin res = (ain - bin + 65536) % 65536; sr = sa - sb; end
            2:       begin res = ain & bin;                   sr = 0;       end
            default: begin res = (~bin) & 65535;              sr = 0;       end
        endcase
        ref_c = res;
        if (sf_i != 0) begin
            ref_z = (res == 0);
            ref_n = (res >= 32768);
            ref_v = (op < 2) && (sr > 32767 || sr < -32768);
        end
        case (ws_i)
            0:       wv = res;
            1:       wv = pc_i;
            2:       wv = imm_i;
            default: wv = md_i;
        endcase
        exp_reg = (we_i != 0) ? wv : ref_r[rd_i];

        alu_op = 2'(op); shift = 2'(sh);
        rn = 3'(rn_i); rm = 3'(rm_i); rd = 3'(rd_i);
        asel = 1'(as_i); bsel = 1'(bs_i); imm = 16'(imm_i);
        wsel = 2'(ws_i); wb_en = 1'(we_i); set_flags = 1'(sf_i);
        dbg_addr = 3'(rd_i);
        op_valid = 1'b1;
        n_checks++;
        if (op_ready !== 1'b1) $display("FAIL %s ready_idle: op_ready=%b want 1", tag, op_ready);
        else n_pass++;

        @(posedge clk); #1;
        op_valid = 1'b0;
        scramble();
        busy_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done !== 1'b0 || op_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!busy_ok) $display("FAIL %s busy_phase: done/op_ready not low for cycles 1..3", tag);
        else n_pass++;

        n_checks++;
        if (done !== 1'b1 || op_ready !== 1'b0)
            $display("FAIL %s done_pulse: done=%b op_ready=%b want 1/0", tag, done, op_ready);
        else n_pass++;
        n_checks++;
        if (result !== 16'(res)) $display("FAIL %s result: got %h want %h", tag, result, 16'(res));
        else n_pass++;
        n_checks++;
        if ({z_out, n_out, v_out} !== {ref_z, ref_n, ref_v})
            $display("FAIL %s flags: got znv=%b%b%b want %b%b%b", tag, z_out, n_out, v_out,
                     ref_z, ref_n, ref_v);
        else n_pass++;
        pc    = 9'(pc_i);
        mdata = 16'(md_i);

        @(posedge clk); #1;
        pc    = 9'($urandom);
        mdata = 16'($urandom);
        n_checks++;
        if (done !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL %s back_idle: done=%b op_ready=%b want 0/1", tag, done, op_ready);
        else n_pass++;
        n_checks++;
        if (dbg_data !== 16'(exp_reg))
            $display("FAIL %s reg_wb: R%0d=%h want %h", tag, rd_i, dbg_data, 16'(exp_reg));
        else n_pass++;
        ref_r[rd_i] = exp_reg;
    endtask

    // Load a register with an immediate (C also becomes the immediate).
    task automatic load_reg(input int r, input int v, input string tag);
        do_op(0, 0, 0, 0, r, 1, 1, v, 2, 1, 0, 0, 0, tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (op_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL reset_hs: op_ready=%b done=%b want 1/0", op_ready, done);
        else n_pass++;
        n_checks++;
        if (result !== 16'h0 || {z_out, n_out, v_out} !== 3'b000)
            $display("FAIL reset_c_flags: result=%h znv=%b%b%b want 0", result, z_out, n_out, v_out);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== 16'h0) $display("FAIL reset_reg: R%0d=%h want 0", i, dbg_data);
            else n_pass++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add_shift();
        load_reg(0, 7, "load_r0");
        load_reg(1, 2, "load_r1");
        do_op(0, 1, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, "add_lsl");
    endtask

    task automatic test_sub_flags();
        load_reg(0, 16'h7FFF, "load_7fff");
        load_reg(1, 16'hFFFF, "load_m1");
        do_op(1, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, "sub_ovf");
        do_op(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, "cmp_eq");
    endtask

    task automatic test_not_hold();
        do_op(3, 0, 0, 0, 3, 1, 1, 16'h00F0, 0, 1, 1, 0, 0, "not_imm");
        do_op(1, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, "flags_hold");
    endtask

    task automatic test_wb_sources();
        do_op(2, 0, 1, 2, 3, 0, 0, 0, 3, 1, 0, 0, 16'hBEEF, "wb_mdata");
        do_op(0, 0, 1, 2, 4, 0, 0, 0, 1, 1, 0, 9'h1A5, 0, "wb_pc");
        do_op(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, "wb_off");
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n_acc, n_done;
        load_reg(2, 1, "load_r2");
        alu_op = 2'd0; shift = 2'd0; rn = 3'd2; rm = 3'd2; rd = 3'd2;
        asel = 1'b0; bsel = 1'b0; wsel = 2'd0; wb_en = 1'b1; set_flags = 1'b0;
        dbg_addr = 3'd2;
        op_valid = 1'b1;
        n_acc = 0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (op_valid && op_ready === 1'b1 && n_acc < 3) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
            if (n_acc == 3) op_valid = 1'b0;
        end
        op_valid = 1'b0;
        ref_r[2] = 8;
        ref_c = 8;
        n_checks++;
        if (n_acc != 3 || n_done != 3)
            $display("FAIL b2b_count: accepts=%0d dones=%0d want 3/3", n_acc, n_done);
        else n_pass++;
        n_checks++;
        if (n_acc == 3 && (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5))
            $display("FAIL b2b_spacing: gaps %0d,%0d want 5,5", acc[1] - acc[0], acc[2] - acc[1]);
        else if (n_acc == 3) n_pass++;
        else $display("FAIL b2b_spacing: only %0d accepts seen", n_acc);
        n_checks++;
        if (dbg_data !== 16'd8) $display("FAIL b2b_chain: R2=%h want 0008", dbg_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        alu_op = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd1; rd = 3'd6;
        asel = 1'b0; bsel = 1'b1; imm = 16'h1234; wsel = 2'd2; wb_en = 1'b1; set_flags = 1'b1;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (done !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL rst_mid_hs: done=%b op_ready=%b want 0/1", done, op_ready);
        else n_pass++;
        n_checks++;
        if (result !== 16'h0 || {z_out, n_out, v_out} !== 3'b000)
            $display("FAIL rst_mid_c: result=%h znv=%b%b%b want 0", result, z_out, n_out, v_out);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== 16'h0) $display("FAIL rst_mid_reg: R%0d=%h want 0", i, dbg_data);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rst_mid_nodone: done=%b want 0", done);
        else n_pass++;
        load_reg(1, 16'h8004, "load_8004");
        do_op(0, 3, 0, 1, 7, 1, 0, 0, 0, 1, 1, 0, 0, "asr1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4) != 0),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 65535)), "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 1'b0;
        alu_op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
        asel = 1'b0; bsel = 1'b0; imm = '0; wsel = '0; wb_en = 1'b0; set_flags = 1'b0;
        pc = '0; mdata = '0; dbg_addr = '0;
        test_reset();
        test_add_shift();
        test_sub_flags();
        test_not_hold();
        test_wb_sources();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Self-sequencing, parametrised datapath: register file, A/B/C pipeline registers, shifter, ALU and status flags.
- Accepts one operation descriptor through a valid/ready handshake and runs its own 5-state sequencer (read A, read B, execute, write back).
- Pulses done with the result, so the controller issues whole operations instead of individual load strobes.
- Sits between the instruction decoder/controller FSM and memory (mdata) / PC logic of the CPU.

Parameters:
- DATA_W, 16, datapath word width (>=4).
- NREG, 8, number of general registers (power of 2, >=2).
- PC_W, 9, program counter width (PC_W <= DATA_W).
- REG_AW, $clog2(NREG), register address width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  descriptor valid.
- op_ready  out  1  block can accept a descriptor.
- alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT(B).
- shift  in  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1; applied to the B operand.
- rn  in  REG_AW  A-operand register.
- rm  in  REG_AW  B-operand register.
- rd  in  REG_AW  destination register.
- asel  in  1  1: A operand = 0.
- bsel  in  1  1: B operand = imm (unshifted).
- imm  in  DATA_W  sign-extended immediate.
- wsel  in  2  writeback source: 00 C, 01 PC (zero-extended), 10 imm, 11 mdata.
- wb_en  in  1  write rd in WB.
- set_flags  in  1  update Z/N/V in EXEC.
- pc  in  PC_W  program counter.
- mdata  in  DATA_W  memory read data.
- done  out  1  one-cycle pulse at end of WB.
- result  out  DATA_W  C register.
- z_out, n_out, v_out  out  1 each  status flags.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of R[dbg_addr].

Behaviour:
- Reset: all registers R[0..NREG-1], A, B and C go to 0; flags go to 0; state goes to IDLE; op_ready=1; done=0. Reset mid-operation aborts the operation, with no writeback and no done.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE, one cycle each.
- op_ready=1 only in IDLE. Accept occurs at edge T when op_valid&&op_ready; all descriptor fields are latched then. op_valid while busy is ignored, and inputs may change freely.
- RD_A (T+1): A <= R[rn].
- RD_B (T+2): B <= R[rm].
- EXEC (T+3):
  - Ain = asel ? 0 : A.
  - Bin = bsel ? imm : shift(B). LSR zero-fills; ASR replicates the MSB.
  - C <= ALU(Ain, Bin), truncated to DATA_W.
  - If set_flags: Z = (alu==0); N = alu[DATA_W-1]; V = signed overflow for ADD/SUB, 0 for AND/NOT.
  - Flags are otherwise held. ADD and SUB are mod 2^DATA_W.
- WB (T+4):
  - If wb_en: R[rd] <= selected source. mdata and pc are sampled live in this cycle; imm is the latched value.
  - done=1 this cycle only.
  - Next state IDLE.
- Latency: done is seen at T+4 (4 cycles after accept). Throughput is 1 op per 5 cycles.
- RAW hazard: the earliest next accept is T+5, so its RD_A at T+6 sees the new value. No forwarding is needed.
- rd==rn==rm is legal; operands are the pre-write values.
- Flags and result hold their values between operations.

Decomposition:
- Package dp_pkg holds: alu_op_e, shift_e, wsel_e, state_e (IDLE, RD_A, RD_B, EXEC, WB), plus the functions alu_f and shift_f.
- One sub-module, dp_regfile: NREG x DATA_W, sync reset to 0, one write port, two combinational read ports (operand, debug).
- The sequencer and the A/B/C/status registers live in seq_datapath.

Test Plan (DATA_W=16, NREG=8):
1. Reset, then load R0=7 (wsel=10, imm=7, wb_en) and R1=2 the same way. Then ADD rd=2, rn=0, rm=1, shift=01 -> done at accept+4, R2=11, result=11, op_ready low for 4 cycles.
2. SUB with R0=0x7FFF, R1=0xFFFF (-1), set_flags -> result=0x8000, N=1, V=1, Z=0. Then CMP R0-R0 -> Z=1, N=0, V=0.
3. NOT with asel=1, bsel=1, imm=0x00F0 -> result=0xFF0F. A following op with set_flags=0 -> flags unchanged.
4. WB sources: wsel=11 with mdata=0xBEEF -> R3=0xBEEF. wsel=01 with pc=9'h1A5 -> R4=0x01A5. wb_en=0 -> R5 stays 0, but done still pulses.
5. op_valid held high continuously across 3 ops -> accepts only in IDLE, spaced 5 cycles apart. A dependent chain (R2=R2+R2 three times, starting at 1) ends at R2=8.
6. Assert reset during EXEC of an op targeting R6 -> R6 and all registers = 0, no done, op_ready=1 on the next cycle. ASR1 of 0x8004 -> 0xC002.
